d_write_buffer: RTL and testbench

D_WRITE_BUFFER -- requirements
Module: d_write_buffer

---
 rtl/d_write_buffer_pkg.sv | 28 ++
 rtl/d_write_buffer_fifo.sv | 55 +++++
 rtl/d_write_buffer.sv | 138 +++++++++++++
 tb/tb_d_write_buffer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/d_write_buffer_pkg.sv
// Shared encodings for the data-side write buffer: FSM states, access sizes
// and the layout of one buffered write entry.
package d_write_buffer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_W_ADDR = 3'd1,
        ST_W_DATA = 3'd2,
        ST_R_ADDR = 3'd3,
        ST_R_DATA = 3'd4
    } wb_state_t;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } wb_size_t;

    localparam int ENTRY_W = 66;

    // One buffered write; packed so it maps 1:1 onto the 66-bit FIFO word.
    typedef struct packed {
        wb_size_t    size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } wb_entry_t;

endpackage

// File: rtl/d_write_buffer_fifo.sv
// DEPTH-entry FIFO holding buffered writes; pointers carry one extra wrap bit
// so full and empty are told apart without a separate flag.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 66
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_en;
    logic             pop_en;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign count   = wr_ptr - rd_ptr;
    // full is sampled before this edge's pop, so a push into a full FIFO waits.
    assign push_en = push & ~full;
    assign pop_en  = pop & ~empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/d_write_buffer.sv
// Write buffer between the d-cache sram-like port and the AXI bridge: writes
// retire into a FIFO immediately, reads wait until every buffered write drained.
module d_write_buffer
    import d_write_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        up_req,
    input  logic        up_wr,
    input  logic [1:0]  up_size,
    input  logic [31:0] up_addr,
    input  logic [31:0] up_wdata,
    output logic [31:0] up_rdata,
    output logic        up_addr_ok,
    output logic        up_data_ok,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    output logic        wb_empty
);

    localparam int PW = $clog2(DEPTH) + 1;

    // Handshake: a request (req) holds its fields stable until addr_ok is seen
    // high in the same cycle; that cycle's rising edge is the transfer. data_ok
    // is a one-cycle completion pulse, at most one transaction outstanding per side.

    wb_state_t   state;
    wb_state_t   state_nxt;
    wb_entry_t   push_entry;
    wb_entry_t   head_entry;
    logic        fifo_full;
    logic        fifo_empty;
    logic [PW-1:0] fifo_count;
    logic        push;
    logic        pop;
    logic        wr_data_ok_q;
    logic        rd_addr_ok;
    logic        rd_data_ok;

    assign push       = up_req & up_wr & ~fifo_full;
    assign push_entry = '{size: wb_size_t'(up_size), addr: up_addr, wdata: up_wdata};

    wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (push_entry),
        .rdata (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            wr_data_ok_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            wr_data_ok_q <= push;
        end
    end

    always_comb begin
        state_nxt  = state;
        mem_req    = 1'b0;
        mem_wr     = 1'b0;
        mem_size   = '0;
        mem_addr   = '0;
        mem_wdata  = '0;
        up_rdata   = '0;
        rd_addr_ok = 1'b0;
        rd_data_ok = 1'b0;
        pop        = 1'b0;
        case (state)
            // Buffered writes always go first, which keeps reads ordered behind them.
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_nxt = ST_W_ADDR;
                end else if (up_req && !up_wr) begin
                    state_nxt = ST_R_ADDR;
                end
            end
            ST_W_ADDR: begin
                mem_req   = 1'b1;
                mem_wr    = 1'b1;
                mem_size  = head_entry.size;
                mem_addr  = head_entry.addr;
                mem_wdata = head_entry.wdata;
                if (mem_addr_ok) begin
                    state_nxt = ST_W_DATA;
                end
            end
            ST_W_DATA: begin
                if (mem_data_ok) begin
                    pop       = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_R_ADDR: begin
                mem_req  = 1'b1;
                mem_size = up_size;
                mem_addr = up_addr;
                if (mem_addr_ok) begin
                    rd_addr_ok = 1'b1;
                    state_nxt  = ST_R_DATA;
                end
            end
            ST_R_DATA: begin
                up_rdata = mem_rdata;
                if (mem_data_ok) begin
                    rd_data_ok = 1'b1;
                    state_nxt  = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign up_addr_ok = push | rd_addr_ok;
    assign up_data_ok = wr_data_ok_q | rd_data_ok;
    assign wb_empty   = (fifo_count == '0) && (state == ST_IDLE);

endmodule

// File: tb/tb_d_write_buffer.sv
// Bench for d_write_buffer: per-cycle vector table for single transactions,
// then hand-written sequences for FIFO full, pop/push collision and reset.
module tb_d_write_buffer;
    import d_write_buffer_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        up_req;
    logic        up_wr;
    logic [1:0]  up_size;
    logic [31:0] up_addr;
    logic [31:0] up_wdata;
    logic [31:0] up_rdata;
    logic        up_addr_ok;
    logic        up_data_ok;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic        wb_empty;

    always #5 clk = ~clk;

    d_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .up_req      (up_req),
        .up_wr       (up_wr),
        .up_size     (up_size),
        .up_addr     (up_addr),
        .up_wdata    (up_wdata),
        .up_rdata    (up_rdata),
        .up_addr_ok  (up_addr_ok),
        .up_data_ok  (up_data_ok),
        .mem_req     (mem_req),
        .mem_wr      (mem_wr),
        .mem_size    (mem_size),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_addr_ok (mem_addr_ok),
        .mem_data_ok (mem_data_ok),
        .wb_empty    (wb_empty)
    );

    typedef struct {
        string       name;
        logic        req;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        maok;
        logic        mdok;
        logic [31:0] mrdata;
        logic [102:0] exp_out;
    } vec_t;

    vec_t        vecs[$];
    logic [63:0] exp_q[$];
    int          passed = 0;
    int          total  = 0;

    // mem fields are don't-care when no request is presented, wdata when reading.
    function automatic logic [102:0] pack_out(input logic aok, input logic dok, input logic mreq,
                                              input logic mwr, input logic empty, input logic [1:0] msize,
                                              input logic [31:0] maddr, input logic [31:0] mwdata,
                                              input logic [31:0] rdata);
        return {aok, dok, mreq, mwr, empty, (mreq ? msize : 2'b00), (mreq ? maddr : 32'h0),
                ((mreq && mwr) ? mwdata : 32'h0), rdata};
    endfunction

    function automatic logic [102:0] outs();
        return pack_out(up_addr_ok, up_data_ok, mem_req, mem_wr, wb_empty, mem_size, mem_addr,
                        mem_wdata, up_rdata);
    endfunction

    function automatic void add(input string n, input logic req, input logic wr, input logic [1:0] size,
                                input logic [31:0] addr, input logic [31:0] wdata, input logic maok,
                                input logic mdok, input logic [31:0] mrdata, input logic aok,
                                input logic dok, input logic mreq, input logic mwr, input logic [1:0] msize,
                                input logic [31:0] maddr, input logic [31:0] mwdata,
                                input logic [31:0] rdata, input logic empty);
        vec_t v;
        v.name    = n;
        v.req     = req;
        v.wr      = wr;
        v.size    = size;
        v.addr    = addr;
        v.wdata   = wdata;
        v.maok    = maok;
        v.mdok    = mdok;
        v.mrdata  = mrdata;
        v.exp_out = pack_out(aok, dok, mreq, mwr, empty, msize, maddr, mwdata, rdata);
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        up_req      = 1'b0;
        up_wr       = 1'b0;
        up_size     = 2'd0;
        up_addr     = 32'h0;
        up_wdata    = 32'h0;
        mem_rdata   = 32'h0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
    endtask

    task automatic drive_write(input logic [31:0] addr, input logic [31:0] data);
        up_req   = 1'b1;
        up_wr    = 1'b1;
        up_size  = 2'd2;
        up_addr  = addr;
        up_wdata = data;
    endtask

    // Bridge model: waits for a write request, checks it against the scoreboard
    // head, then gives addr_ok and data_ok one cycle apart.
    task automatic serve_write(input string name);
        logic [63:0] exp;
        bit          seen;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            #1;
            if (mem_req && mem_wr) begin
                seen = 1'b1;
                if (exp_q.size() == 0) begin
                    check({name, "_unexpected"}, {mem_addr, mem_wdata}, 64'h0);
                end else begin
                    exp = exp_q.pop_front();
                    check(name, {mem_addr, mem_wdata}, exp);
                end
                mem_addr_ok = 1'b1;
                @(negedge clk);
                mem_addr_ok = 1'b0;
                mem_data_ok = 1'b1;
                @(negedge clk);
                mem_data_ok = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        if (!seen) begin
            check({name, "_timeout"}, 1'b0, 1'b1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int mem_req_cycles;

        drive_idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1 check("reset_outputs", outs(), pack_out(0, 0, 0, 0, 1, 2'd0, 32'h0, 32'h0, 32'h0));
        rst = 1'b0;
        @(negedge clk);

        // Single word write.
        add("w1_push",  1, 1, 2, 32'h8000_0010, 32'hDEAD_BEEF, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 1);
        add("w1_dok",   0, 0, 0, 0, 0, 0, 0, 0,                            0, 1, 0, 0, 0, 0, 0, 0, 0);
        add("w1_maddr", 0, 0, 0, 0, 0, 1, 0, 0,                            0, 0, 1, 1, 2, 32'h8000_0010, 32'hDEAD_BEEF, 0, 0);
        add("w1_mdata", 0, 0, 0, 0, 0, 0, 1, 0,                            0, 0, 0, 0, 0, 0, 0, 0, 0);
        add("w1_idle",  0, 0, 0, 0, 0, 0, 0, 0,                            0, 0, 0, 0, 0, 0, 0, 0, 1);
        // Byte write followed by a read that must wait for the write to drain.
        add("wr_push",       1, 1, 0, 32'h100, 32'h11, 0, 0, 0,            1, 0, 0, 0, 0, 0, 0, 0, 1);
        add("wr_rd_wait0",   1, 0, 2, 32'h100, 0, 0, 0, 0,                 0, 1, 0, 0, 0, 0, 0, 0, 0);
        add("wr_waddr",      1, 0, 2, 32'h100, 0, 1, 0, 0,                 0, 0, 1, 1, 0, 32'h100, 32'h11, 0, 0);
        add("wr_wdata_wait", 1, 0, 2, 32'h100, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add("wr_wdata_ok",   1, 0, 2, 32'h100, 0, 0, 1, 0,                 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add("wr_idle_rd",    1, 0, 2, 32'h100, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add("wr_raddr",      1, 0, 2, 32'h100, 0, 1, 0, 0,                 1, 0, 1, 0, 2, 32'h100, 0, 0, 0);
        add("wr_rdata",      0, 0, 0, 0, 0, 0, 1, 32'hCAFE_F00D,           0, 1, 0, 0, 0, 0, 0, 32'hCAFE_F00D, 0);
        add("wr_idle",       0, 0, 0, 0, 0, 0, 0, 0,                       0, 0, 0, 0, 0, 0, 0, 0, 1);
        // Idle read with addr_ok 3 cycles late and data_ok 2 cycles after that.
        add("rd_idle",  1, 0, 2, 32'h2000_0004, 0, 0, 0, 0,                0, 0, 0, 0, 0, 0, 0, 0, 1);
        add("rd_wait1", 1, 0, 2, 32'h2000_0004, 0, 0, 0, 32'h5555_5555,    0, 0, 1, 0, 2, 32'h2000_0004, 0, 0, 0);
        add("rd_wait2", 1, 0, 2, 32'h2000_0004, 0, 0, 0, 0,                0, 0, 1, 0, 2, 32'h2000_0004, 0, 0, 0);
        add("rd_wait3", 1, 0, 2, 32'h2000_0004, 0, 0, 0, 0,                0, 0, 1, 0, 2, 32'h2000_0004, 0, 0, 0);
        add("rd_aok",   1, 0, 2, 32'h2000_0004, 0, 1, 0, 0,                1, 0, 1, 0, 2, 32'h2000_0004, 0, 0, 0);
        add("rd_dwait", 0, 0, 0, 0, 0, 0, 0, 0,                            0, 0, 0, 0, 0, 0, 0, 0, 0);
        add("rd_dok",   0, 0, 0, 0, 0, 0, 1, 32'h1234_5678,                0, 1, 0, 0, 0, 0, 0, 32'h1234_5678, 0);
        add("rd_done",  0, 0, 0, 0, 0, 0, 0, 0,                            0, 0, 0, 0, 0, 0, 0, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            up_req      = vecs[i].req;
            up_wr       = vecs[i].wr;
            up_size     = vecs[i].size;
            up_addr     = vecs[i].addr;
            up_wdata    = vecs[i].wdata;
            mem_addr_ok = vecs[i].maok;
            mem_data_ok = vecs[i].mdok;
            mem_rdata   = vecs[i].mrdata;
            #1 check(vecs[i].name, outs(), vecs[i].exp_out);
            @(negedge clk);
        end
        drive_idle();

        // Five back-to-back writes with the bridge stalled: four fit, the fifth waits.
        for (int i = 0; i < 4; i++) begin
            drive_write(32'h1000 + 32'(4 * i), 32'hA0 + 32'(i));
            exp_q.push_back({32'h1000 + 32'(4 * i), 32'hA0 + 32'(i)});
            #1 check($sformatf("fill_aok%0d", i), up_addr_ok, 1'b1);
            @(negedge clk);
        end
        drive_write(32'h1010, 32'hA4);
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("full_hold%0d", i), up_addr_ok, 1'b0);
            @(negedge clk);
        end
        mem_addr_ok = 1'b1;
        #1 check("full_head_issue", {mem_req, mem_wr, mem_size, mem_addr, mem_wdata},
                 {1'b1, 1'b1, 2'd2, exp_q.pop_front()});
        @(negedge clk);
        // Pop and a push into the full FIFO on the same edge: the push must wait.
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        #1 check("pop_edge_aok", up_addr_ok, 1'b0);
        @(negedge clk);
        mem_data_ok = 1'b0;
        #1 check("after_pop_aok", up_addr_ok, 1'b1);
        exp_q.push_back({32'h1010, 32'hA4});
        @(negedge clk);
        up_req = 1'b0;
        up_wr  = 1'b0;
        #1 check("refill_count", dut.u_fifo.count, 3'd4);
        for (int i = 0; i < 4; i++) begin
            serve_write($sformatf("drain_order%0d", i));
        end
        #1 check("drain_wb_empty", wb_empty, 1'b1);
        @(negedge clk);

        // Reset while a write is in W_DATA with three entries buffered.
        for (int i = 0; i < 3; i++) begin
            drive_write(32'h3000 + 32'(4 * i), 32'hB0 + 32'(i));
            mem_addr_ok = (i == 2);
            #1 check($sformatf("rst_fill_aok%0d", i), up_addr_ok, 1'b1);
            @(negedge clk);
        end
        drive_idle();
        #1 check("pre_rst_state", {mem_req, wb_empty, up_addr_ok}, 3'b000);
        rst = 1'b1;
        #1 check("rst_immediate", {wb_empty, mem_req, up_data_ok, up_addr_ok}, 4'b1000);
        @(negedge clk);
        rst = 1'b0;
        mem_req_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (mem_req) begin
                mem_req_cycles++;
            end
            @(negedge clk);
        end
        check("post_rst_no_traffic", mem_req_cycles, 0);
        #1 check("post_rst_wb_empty", wb_empty, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
